// File: rtl/cipher_request_initiator_if.sv
// Handshake bundle between the cipher request initiator and its neighbours:
// upstream source, cipher responder and downstream result sink.
interface cipher_request_initiator_if #(
  parameter int DATA_W = 8
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic [DATA_W-1:0] req_data;
  logic              input_request;
  logic              peer_done;
  logic [DATA_W-1:0] peer_data;
  logic              output_acknowledge;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  src_valid, src_data, peer_done, peer_data, res_ready,
    output src_ready, req_data, input_request, output_acknowledge,
           res_valid, res_data, busy, timeout_err
  );

  modport slave (
    output src_valid, src_data, peer_done, peer_data, res_ready,
    input  src_ready, req_data, input_request, output_acknowledge,
           res_valid, res_data, busy, timeout_err
  );
endinterface

// File: rtl/cipher_request_initiator.sv
// Initiator side of the stream-cipher request/done/acknowledge handshake with timeout guard.
// Optional: define INITIATOR_RETRY_EN to re-issue a word once after its first timeout.
module cipher_request_initiator #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  cipher_request_initiator_if.master bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_DONE,
    ACK,
    WAIT_RELEASE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;
  logic             expire;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign accept  = (state == IDLE) && bus.src_valid && bus.src_ready;
  assign capture = (state == WAIT_DONE) && bus.peer_done;
  // peer_done takes priority, so a result arriving on the last allowed cycle is kept
  assign expire  = (state == WAIT_DONE) && !bus.peer_done && (cnt == CNT_LAST);

`ifdef INITIATOR_RETRY_EN
  logic retry;

  always_ff @(posedge clk) begin
    if (rst)          retry <= 1'b0;
    else if (capture) retry <= 1'b0;
    else if (expire)  retry <= !retry;
  end

  assign drop = expire && retry;
`else
  assign drop = expire;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (accept) state_nxt = REQUEST;
      REQUEST:      state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (capture)     state_nxt = ACK;
        else if (expire) state_nxt = drop ? IDLE : REQUEST;
      end
      ACK:          state_nxt = WAIT_RELEASE;
      // holding here until done drops stops one result from being captured twice
      WAIT_RELEASE: if (!bus.peer_done) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.src_ready          = (state == IDLE) && (!bus.res_valid || bus.res_ready);
    bus.input_request      = (state == REQUEST);
    bus.output_acknowledge = (state == ACK);
    bus.busy               = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_data    <= '0;
      bus.res_data    <= '0;
      bus.res_valid   <= 1'b0;
      bus.timeout_err <= 1'b0;
      cnt             <= '0;
    end else begin
      if (accept) bus.req_data <= bus.src_data;

      if (state == REQUEST)        cnt <= '0;
      else if (state == WAIT_DONE) cnt <= sat_inc(cnt);

      if (capture) begin
        bus.res_data  <= bus.peer_data;
        bus.res_valid <= 1'b1;
      end else if (bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end

      if (drop) bus.timeout_err <= 1'b1;
    end
  end

endmodule
